// File: rtl/jt900h_div.sv
// jt900h_div: iterative restoring divider for the TLCS-900H DIV/DIVS
// instructions. Byte op divides 16/8 and word op divides 32/16. The packed
// {remainder, quotient} result and the V flag come back through a
// start/busy/done handshake after a fixed number of cen-high cycles.
module jt900h_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        start,
  input  logic [2:0]  w,
  input  logic        sgn,
  input  logic [31:0] op0,
  input  logic [15:0] op1,
  output logic        busy,
  output logic        done,
  output logic        v,
  output logic [31:0] dout
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] op0_q, op0_d;
  logic [15:0] op1_q, op1_d;
  logic        byte_q, byte_d, sgn_q, sgn_d;
  logic [15:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, byp_q, byp_d;
  logic        busy_q, busy_d, done_q, done_d, v_q, v_d;
  logic [31:0] dout_q, dout_d;

  logic        legal_w;
  logic        dnd_neg, dvs_neg;
  logic [31:0] dnd_mag;
  logic [15:0] dvs_mag, hi_half, lo_half;
  logic [16:0] trial;
  logic [15:0] quo_mag, rem_mag, quo_s, rem_s, lim;
  logic        ovf;
  logic [31:0] result, bypass;

  assign legal_w = (w == 3'b001) || (w == 3'b010);

  // Magnitudes of the latched operands, split into the half compared for
  // early overflow and the half (left-aligned) shifted in by the iterations.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, otherwise a latch is inferred.
    dnd_neg = 1'b0;
    dvs_neg = 1'b0;
    dnd_mag = 32'd0;
    dvs_mag = 16'd0;
    hi_half = 16'd0;
    lo_half = 16'd0;
    if (byte_q) begin
      dnd_neg = sgn_q & op0_q[15];
      dvs_neg = sgn_q & op1_q[7];
      dnd_mag = {16'd0, dnd_neg ? (~op0_q[15:0] + 16'd1) : op0_q[15:0]};
      dvs_mag = {8'd0, dvs_neg ? (~op1_q[7:0] + 8'd1) : op1_q[7:0]};
      hi_half = {8'd0, dnd_mag[15:8]};
      lo_half = {dnd_mag[7:0], 8'd0};
    end else begin
      dnd_neg = sgn_q & op0_q[31];
      dvs_neg = sgn_q & op1_q[15];
      dnd_mag = dnd_neg ? (~op0_q + 32'd1) : op0_q;
      dvs_mag = dvs_neg ? (~op1_q + 16'd1) : op1_q;
      hi_half = dnd_mag[31:16];
      lo_half = dnd_mag[15:0];
    end
  end

  // Restoring trial subtraction plus sign fix-up and signed range check.
  // Since rem < divisor holds between steps, bit 16 of trial is the borrow.
  always_comb begin
    trial   = {rem_q, quo_q[15]} - {1'b0, dvs_q};
    quo_mag = byte_q ? {8'd0, quo_q[7:0]} : quo_q;
    rem_mag = byte_q ? {8'd0, rem_q[7:0]} : rem_q;
    quo_s   = qneg_q ? (~quo_mag + 16'd1) : quo_mag;
    rem_s   = rneg_q ? (~rem_mag + 16'd1) : rem_mag;
    lim     = byte_q ? (qneg_q ? 16'h0080 : 16'h007F)
                     : (qneg_q ? 16'h8000 : 16'h7FFF);
    ovf     = byp_q | (sgn_q & (quo_mag > lim));
    result  = byte_q ? {16'd0, rem_s[7:0], quo_s[7:0]} : {rem_s, quo_s};
    bypass  = byte_q ? {16'd0, op0_q[15:0]} : op0_q;
  end

  // Next-state and datapath control; everything holds while cen is low.
  always_comb begin
    state_d = state_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    byte_d  = byte_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    byp_d   = byp_q;
    busy_d  = busy_q;
    done_d  = done_q;
    v_d     = v_q;
    dout_d  = dout_q;
    if (cen) begin
      case (state_q)
        S_IDLE: begin
          done_d = 1'b0;
          if (start && legal_w) begin
            op0_d   = op0;
            op1_d   = op1;
            byte_d  = w[0];
            sgn_d   = sgn;
            busy_d  = 1'b1;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          qneg_d = dnd_neg ^ dvs_neg;
          rneg_d = dnd_neg;
          if (dvs_mag == 16'd0 || hi_half >= dvs_mag) begin
            byp_d   = 1'b1;
            state_d = S_FIX;
          end else begin
            byp_d   = 1'b0;
            rem_d   = hi_half;
            quo_d   = lo_half;
            dvs_d   = dvs_mag;
            cnt_d   = byte_q ? 5'd8 : 5'd16;
            state_d = S_ITER;
          end
        end
        S_ITER: begin
          if (!trial[16]) begin
            rem_d = trial[15:0];
            quo_d = {quo_q[14:0], 1'b1};
          end else begin
            rem_d = {rem_q[14:0], quo_q[15]};
            quo_d = {quo_q[14:0], 1'b0};
          end
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = S_FIX;
        end
        S_FIX: begin
          v_d     = ovf;
          dout_d  = ovf ? bypass : result;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op0_q   <= 32'd0;
      op1_q   <= 16'd0;
      byte_q  <= 1'b0;
      sgn_q   <= 1'b0;
      rem_q   <= 16'd0;
      quo_q   <= 16'd0;
      dvs_q   <= 16'd0;
      cnt_q   <= 5'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      byp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v_q     <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      byte_q  <= byte_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      byp_q   <= byp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      v_q     <= v_d;
      dout_q  <= dout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign v    = v_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_jt900h_div.sv
// tb_jt900h_div: directed bench for jt900h_div. Expected results are pushed
// to a scoreboard queue as each operation is launched and popped on done.
module tb_jt900h_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  w = 3'b000;
  logic        sgn = 1'b0;
  logic [31:0] op0 = 32'd0;
  logic [15:0] op1 = 16'd0;
  logic        busy, done, v;
  logic [31:0] dout;

  typedef struct {
    logic [31:0] dout;
    logic        v;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  jt900h_div dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cen  (cen),
    .start(start),
    .w    (w),
    .sgn  (sgn),
    .op0  (op0),
    .op1  (op1),
    .busy (busy),
    .done (done),
    .v    (v),
    .dout (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation, count cen-high cycles until done, then compare.
  task automatic run_op(input string tag, input logic [2:0] wi, input logic si,
                        input logic [31:0] a, input logic [15:0] b,
                        input logic [31:0] ed, input logic ev, input int elat,
                        input bit toggle_cen, input bit poke);
    exp_t e;
    int   cyc;
    bit   got, busy_ok;
    sb.push_back('{dout: ed, v: ev, lat: elat});
    @(negedge clk);
    w = wi; sgn = si; op0 = a; op1 = b; start = 1'b1; cen = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1; got = 0; busy_ok = 1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
      end else begin
        if (busy !== 1'b1) busy_ok = 0;
        if (poke && cyc == 4) begin
          start = 1'b1; op0 = 32'hFFFF_FFFF; op1 = 16'h0001; sgn = ~si;
        end else begin
          start = 1'b0;
        end
        cen = toggle_cen ? ~cen : 1'b1;
        @(posedge clk);
        if (cen) cyc++;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, "/done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "/latency"}, 32'(cyc), 32'(e.lat));
    check({tag, "/dout"}, dout, e.dout);
    check({tag, "/v"}, {31'd0, v}, {31'd0, e.v});
    check({tag, "/busy_during"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "/busy_at_done"}, {31'd0, busy}, 32'd0);
    cen = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "/done_pulse"}, {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "/idle_after"}, {31'd0, busy}, 32'd0);
    check({tag, "/dout_hold"}, dout, e.dout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done, was_busy;

    // Reset state
    #12;
    check("reset/busy", {31'd0, busy}, 32'd0);
    check("reset/done", {31'd0, done}, 32'd0);
    check("reset/v", {31'd0, v}, 32'd0);
    check("reset/dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cen = 1'b1;

    // Main function
    run_op("byte_div",   3'b001, 1'b0, 32'h0000_0064, 16'h0007, 32'h0000_020E, 1'b0, 11, 0, 0);
    run_op("word_div",   3'b010, 1'b0, 32'h0001_0000, 16'h0003, 32'h0001_5555, 1'b0, 19, 0, 0);
    run_op("byte_divs",  3'b001, 1'b1, 32'h0000_FFF9, 16'h0002, 32'h0000_FFFD, 1'b0, 11, 0, 0);
    run_op("word_div0",  3'b010, 1'b0, 32'h1234_5678, 16'h0000, 32'h1234_5678, 1'b1, 3, 0, 0);
    run_op("byte_early", 3'b001, 1'b0, 32'h0000_0200, 16'h0002, 32'h0000_0200, 1'b1, 3, 0, 0);
    run_op("byte_sovf",  3'b001, 1'b1, 32'h0000_0080, 16'h0001, 32'h0000_0080, 1'b1, 11, 0, 0);
    run_op("byte_smin",  3'b001, 1'b1, 32'h0000_FF80, 16'h0001, 32'h0000_0080, 1'b0, 11, 0, 0);
    run_op("byte_negdv", 3'b001, 1'b1, 32'h0000_0100, 16'h0080, 32'h0000_00FE, 1'b0, 11, 0, 0);
    run_op("word_smin",  3'b010, 1'b1, 32'h0000_8000, 16'hFFFF, 32'h0000_8000, 1'b0, 19, 0, 0);

    // cen toggling during a word DIVS: -100000 / 7 = -14285 rem -5
    run_op("word_cen",   3'b010, 1'b1, 32'hFFFE_7960, 16'h0007, 32'hFFFB_C833, 1'b0, 19, 1, 0);

    // start pulsed while busy with different operands: ignored, not queued
    run_op("word_poke",  3'b010, 1'b0, 32'h0000_FFFF, 16'h0010, 32'h000F_0FFF, 1'b0, 19, 0, 1);

    // Reset asserted at cycle 5 of a word op
    @(negedge clk);
    w = 3'b010; sgn = 1'b0; op0 = 32'h0001_0000; op1 = 16'h0003; start = 1'b1; cen = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort/busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort/busy", {31'd0, busy}, 32'd0);
    check("abort/done", {31'd0, done}, 32'd0);
    check("abort/v", {31'd0, v}, 32'd0);
    check("abort/dout", dout, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check("abort/no_done", {31'd0, seen_done}, 32'd0);

    // Illegal widths: w=3'b100 and w=3'b000 are ignored
    @(negedge clk);
    w = 3'b100; op0 = 32'h0000_0064; op1 = 16'h0007; start = 1'b1;
    @(posedge clk);
    #1 w = 3'b000;
    @(posedge clk);
    #1 start = 1'b0;
    seen_done = 0; was_busy = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (done) seen_done = 1;
      if (busy) was_busy = 1;
    end
    check("illegal_w/busy", {31'd0, was_busy}, 32'd0);
    check("illegal_w/done", {31'd0, seen_done}, 32'd0);

    // Still operational afterwards
    run_op("byte_after", 3'b001, 1'b0, 32'h0000_0064, 16'h0007, 32'h0000_020E, 1'b0, 11, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jt900h_div.md
# jt900h_div

Iterative divider for the TLCS-900H DIV and DIVS instructions. It works alongside the single-cycle ALU. The control unit hands it a dividend, a divisor, a width and a signedness flag. It returns a packed {remainder, quotient} word plus the V flag after a fixed, width-dependent number of clock-enabled cycles. It uses a start/busy/done handshake so the sequencer can stall while the division runs.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only when high
- start  in  1  request; sampled on a cen cycle while idle
- w  in  3  one-hot width: w[0]=byte op (16/8), w[1]=word op (32/16); w[2] or zero is an illegal value; start is ignored
- sgn  in  1  1=DIVS (two's complement), 0=DIV
- op0  in  32  dividend: op0[15:0] in byte op, op0[31:0] in word op
- op1  in  16  divisor: op1[7:0] in byte op, op1[15:0] in word op
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cen-cycle pulse; dout and v valid
- v  out  1  overflow / divide-by-zero flag
- dout  out  32  result: byte op {16'd0, rem8, quo8}; word op {rem16, quo16}

## Operation
- Operands, w and sgn are latched on accept. Later input changes are ignored until done.
- States: IDLE, PREP, ITER, FIX, DONE.
- **IDLE:** start with legal w moves to PREP.
- **PREP:**
  - Form magnitudes |dividend| and |divisor|. These are unsigned when sgn=0.
  - Divisor==0: v=1, go to DONE via FIX with the bypass result.
  - High half of |dividend| >= |divisor| (n=8 or 16 bits): early overflow, v=1, bypass.
  - Otherwise load the iteration counter with n and go to ITER.
- **ITER:**
  - One restoring step per cen cycle: shift the partial remainder left, bring in the next dividend bit, trial-subtract the divisor.
  - Keep the difference if it is non-negative; the quotient bit is 1 in that case.
  - Decrement the counter and leave after n steps.
- **FIX:**
  - Signed only: negate the quotient when the operand signs differ. Give the remainder the dividend's sign, so the quotient truncates toward zero.
  - Signed overflow when the quotient magnitude exceeds 2^(n-1) (signs differ) or 2^(n-1)-1 (signs equal). This sets v=1 with the bypass result.
- **Bypass result (any v=1):** dout equals the latched dividend, zero-extended to 32 bits in byte op. The destination register is therefore rewritten unchanged.
- **DONE:** assert done and drop busy; the next cen cycle returns to IDLE.
- Only V is produced. S, Z, H, N and C are not driven by this block.
- dout and v hold their last values until the next done. They are not cleared in IDLE.

## Timing
- Reset: busy=0, done=0, v=0, dout=0, state IDLE, counter 0. Reset asserted mid-operation aborts immediately and no done pulse is emitted.
- Cycle counts are in cen-high cycles, with cycle 0 being accept:
  - PREP at cycle 1.
  - ITER at cycles 2..n+1.
  - FIX at cycle n+2.
  - done=1 at cycle n+3: byte op 11, word op 19.
  - Divide-by-zero or early overflow: done at cycle 3.
- busy rises at cycle 1 and falls in the done cycle.
- A start asserted while busy or done is ignored; it is not queued. A start in the cycle after done is accepted.
- cen low freezes every register including done, so a done pulse lasts exactly one cen-high cycle.
- Back-to-back minimum spacing between accepts: n+4 cen cycles.

## Test plan
- Byte DIV 0x0064/0x07: dout=0x0000_020E, v=0, done at cycle 11, busy high cycles 1-10.
- Word DIV 0x0001_0000/0x0003: dout=0x0001_5555, v=0, done at cycle 19.
- Byte DIVS 0xFFF9/0x02 (-7/2): dout=0x0000_FFFD (quo -3, rem -1), v=0.
- Word DIV 0x1234_5678/0x0000: v=1, dout=0x1234_5678, done at cycle 3. Byte DIV 0x0200/0x02: v=1, dout=0x0000_0200, done at cycle 3.
- Byte DIVS 0x0080/0x01: v=1 from FIX, dout=0x0000_0080, done at cycle 11. Byte DIVS 0xFF80/0x01 (-128/1): v=0, dout=0x0000_0080.
- Control cases:
  - cen toggled 50% during a word op: done still after 19 cen-high cycles.
  - start pulsed while busy: ignored.
  - rst_n low at cycle 5: all outputs 0, no done.
  - w=3'b100 with start: stays IDLE.
